branch_target_buffer: RTL and testbench
=======================================

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 The block SHALL have parameter ENTRY_NUM, default 16, meaning the number of direct-mapped entries (power of two, 4..256).
REQ-002 The block SHALL have parameter PC_WIDTH, default 32, meaning the instruction address width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-005 The block SHALL have port pc, input, PC_WIDTH bits: the current fetch PC, driven by the fetch stage.
REQ-006 The block SHALL have port btbHit, output, 1 bit: high when the fetch PC is predicted taken.
REQ-007 The block SHALL have port btbPredictedPc, output, PC_WIDTH bits: the predicted next fetch PC.
REQ-008 The block SHALL have port updateEn, input, 1 bit: a resolved branch/jump is presented this cycle.
REQ-009 The block SHALL have port updatePc, input, PC_WIDTH bits: the PC of the resolved branch.
REQ-010 The block SHALL have port updateTaken, input, 1 bit: the resolved direction (1 = taken).
REQ-011 The block SHALL have port updateTarget, input, PC_WIDTH bits: the resolved taken target.
REQ-012 The block SHALL have port flushAll, input, 1 bit: invalidate every entry (fence.i / context change).

Function
REQ-013 Each entry SHALL hold: valid (1b), tag (PC_WIDTH-IDX-2 b), target (PC_WIDTH b), and ctr (2b saturating counter); IDX = log2(ENTRY_NUM).
REQ-014 The index SHALL be addr[IDX+1:2]; the tag SHALL be addr[PC_WIDTH-1:IDX+2]; addr[1:0] is ignored.
REQ-015 The lookup SHALL be combinational from pc, with zero-cycle latency: btbHit = valid && tag match && ctr[1].
REQ-016 btbPredictedPc SHALL equal the entry target when btbHit=1, else pc+4, truncated modulo 2^PC_WIDTH (wrap at 0xFFFFFFFC -> 0x00000000).
REQ-017 A write SHALL become visible on the cycle after updateEn; a same-cycle lookup of the same index SHALL return the pre-update contents.
REQ-018 On updateEn with a valid tag match, ctr SHALL saturate-increment if updateTaken, else saturate-decrement; ctr range 0..3, no wrap.
REQ-019 On a matching entry with updateTaken=1, target SHALL be overwritten with updateTarget; with updateTaken=0, target is unchanged.
REQ-020 On updateEn with a miss (invalid or tag mismatch) and updateTaken=1, the entry SHALL be allocated/replaced: valid=1, tag=updatePc tag, target=updateTarget, ctr=2'b10.
REQ-021 On updateEn with a miss and updateTaken=0, no state SHALL change.
REQ-022 flushAll SHALL clear every valid bit on the next edge; tags, targets, and ctr are don't-care.
REQ-023 flushAll and updateEn in the same cycle: flush SHALL win and the update SHALL be dropped.
REQ-024 Only the indexed entry SHALL change on update; all other entries SHALL hold.

Reset
REQ-025 rst=1 at a rising edge SHALL clear all valid bits; ctr SHALL reset to 2'b01; rst overrides updateEn and flushAll.
REQ-026 After reset, btbHit SHALL be 0 and btbPredictedPc SHALL be pc+4 for every pc until the first taken update.
REQ-027 An update presented in the same cycle as rst SHALL be discarded.

Verification
REQ-028 Reset, then pc=0x100 -> btbHit=0, btbPredictedPc=0x104.
REQ-029 updateEn, updatePc=0x100, taken, target=0x200; next cycle pc=0x100 -> btbHit=1, btbPredictedPc=0x200; in the update cycle itself, btbHit=0.
REQ-030 From ctr=2 at 0x100, one not-taken update -> ctr=1, btbHit=0; two taken updates -> ctr=3; a third taken update keeps ctr=3; four not-taken updates -> ctr=0.
REQ-031 Alias: entry at 0x100 valid; taken update at 0x140 (same index, ENTRY_NUM=16) with target 0x300 -> 0x140 hits to 0x300, 0x100 misses with btbPredictedPc=0x104; a not-taken miss at 0x180 changes nothing.
REQ-032 flushAll and updateEn asserted together with several valid entries -> all lookups miss next cycle, and the update is not installed.
REQ-033 pc=0xFFFFFFFC on a miss -> btbPredictedPc=0x00000000.

Source files
------------

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit counters.
// Zero-latency lookup from pc; updates land on the next edge.
module branch_target_buffer #(
  parameter int ENTRY_NUM = 16,
  parameter int PC_WIDTH  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] pc,
  output logic                btbHit,
  output logic [PC_WIDTH-1:0] btbPredictedPc,
  input  logic                updateEn,
  input  logic [PC_WIDTH-1:0] updatePc,
  input  logic                updateTaken,
  input  logic [PC_WIDTH-1:0] updateTarget,
  input  logic                flushAll
);

  localparam int IDX  = $clog2(ENTRY_NUM);
  localparam int TAGW = PC_WIDTH - IDX - 2;

  logic [ENTRY_NUM-1:0] valid;
  logic [TAGW-1:0]      tagMem    [ENTRY_NUM];
  logic [PC_WIDTH-1:0]  targetMem [ENTRY_NUM];
  logic [1:0]           ctrMem    [ENTRY_NUM];

  logic [IDX-1:0]  lookIdx;
  logic [IDX-1:0]  updIdx;
  logic [TAGW-1:0] lookTag;
  logic [TAGW-1:0] updTag;
  logic [1:0]      curCtr;
  logic [1:0]      ctrNext;
  logic            updMatch;
  logic            doUpd;
  logic            doAlloc;
  logic            doTrain;
  logic            unusedBits;

  assign lookIdx = pc[IDX+1:2];
  assign lookTag = pc[PC_WIDTH-1:IDX+2];
  assign updIdx  = updatePc[IDX+1:2];
  assign updTag  = updatePc[PC_WIDTH-1:IDX+2];

  // byte offset within a word never selects an entry
  assign unusedBits = ^{pc[1:0], updatePc[1:0]};

  assign btbHit = valid[lookIdx]
               && (tagMem[lookIdx] == lookTag)
               && ctrMem[lookIdx][1];

  assign btbPredictedPc = btbHit ? targetMem[lookIdx]
                                 : pc + PC_WIDTH'(4);

  assign updMatch = valid[updIdx]
                 && (tagMem[updIdx] == updTag);

  // reset and flush both squash a concurrent update
  assign doUpd   = !rst && !flushAll && updateEn;
  assign doAlloc = doUpd && !updMatch && updateTaken;
  assign doTrain = doUpd && updMatch;

  assign curCtr = ctrMem[updIdx];

  always_comb begin
    ctrNext = curCtr;
    unique case (1'b1)
      doAlloc:
        ctrNext = 2'b10;
      doTrain && updateTaken && (curCtr != 2'b11):
        ctrNext = curCtr + 2'b01;
      doTrain && !updateTaken && (curCtr != 2'b00):
        ctrNext = curCtr - 2'b01;
      default:
        ctrNext = curCtr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < ENTRY_NUM; i++) begin
        ctrMem[i] <= 2'b01;
      end
    end else begin
      if (flushAll) begin
        valid <= '0;
      end else if (doAlloc) begin
        valid[updIdx] <= 1'b1;
      end
      if (doAlloc || doTrain) begin
        ctrMem[updIdx] <= ctrNext;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (doAlloc) begin
      tagMem[updIdx] <= updTag;
    end
    if (doAlloc || (doTrain && updateTaken)) begin
      targetMem[updIdx] <= updateTarget;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Vector table plus scoreboard bench for branch_target_buffer.
// Inputs change on negedge; outputs are checked just after.
module tb_branch_target_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        btbHit;
  logic [31:0] btbPredictedPc;
  logic        updateEn;
  logic [31:0] updatePc;
  logic        updateTaken;
  logic [31:0] updateTarget;
  logic        flushAll;

  int tests;
  int fails;

  typedef struct {
    string       name;
    logic        rst;
    logic        flush;
    logic        upd;
    logic        taken;
    logic [31:0] updPc;
    logic [31:0] updTgt;
    logic [31:0] pc;
    logic        expHit;
    logic [31:0] expPc;
  } vec_t;

  typedef struct {
    string       name;
    logic        hit;
    logic [31:0] npc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  branch_target_buffer #(
    .ENTRY_NUM(16),
    .PC_WIDTH (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc            (pc),
    .btbHit        (btbHit),
    .btbPredictedPc(btbPredictedPc),
    .updateEn      (updateEn),
    .updatePc      (updatePc),
    .updateTaken   (updateTaken),
    .updateTarget  (updateTarget),
    .flushAll      (flushAll)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    string n, logic r, logic f, logic u, logic t,
    logic [31:0] up, logic [31:0] ut, logic [31:0] p,
    logic eh, logic [31:0] ep);
    vec_t v;
    v.name = n; v.rst = r; v.flush = f; v.upd = u;
    v.taken = t; v.updPc = up; v.updTgt = ut; v.pc = p;
    v.expHit = eh; v.expPc = ep;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst          = v.rst;
    flushAll     = v.flush;
    updateEn     = v.upd;
    updateTaken  = v.taken;
    updatePc     = v.updPc;
    updateTarget = v.updTgt;
    pc           = v.pc;
    e.name = v.name; e.hit = v.expHit; e.npc = v.expPc;
    sb.push_back(e);
    #1;
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      got = sb.pop_front();
      tests++;
      if (btbHit !== got.hit || btbPredictedPc !== got.npc) begin
        fails++;
        $display("FAIL %s: got hit=%b pc=%h, want hit=%b pc=%h",
                 got.name, btbHit, btbPredictedPc, got.hit, got.npc);
      end
    end
  endtask

  initial begin
    rst = 1'b1; flushAll = 1'b0; updateEn = 1'b0;
    updateTaken = 1'b0; updatePc = '0; updateTarget = '0;
    pc = '0; tests = 0; fails = 0;
    repeat (2) @(posedge clk);

    vecs.push_back(mk("reset_miss",   0,0,0,0, 0,0, 32'h100, 0, 32'h104));
    vecs.push_back(mk("alloc_same",   0,0,1,1, 32'h100,32'h200, 32'h100, 0, 32'h104));
    vecs.push_back(mk("alloc_hit",    0,0,0,0, 0,0, 32'h100, 1, 32'h200));
    vecs.push_back(mk("nt_pre",       0,0,1,0, 32'h100,32'hDEAD0, 32'h100, 1, 32'h200));
    vecs.push_back(mk("ctr1_miss",    0,0,0,0, 0,0, 32'h100, 0, 32'h104));
    vecs.push_back(mk("t_ctr1",       0,0,1,1, 32'h100,32'h200, 32'h100, 0, 32'h104));
    vecs.push_back(mk("t_ctr2",       0,0,1,1, 32'h100,32'h200, 32'h100, 1, 32'h200));
    vecs.push_back(mk("t_ctr3",       0,0,1,1, 32'h100,32'h200, 32'h100, 1, 32'h200));
    vecs.push_back(mk("nt_sat3",      0,0,1,0, 32'h100,32'hDEAD0, 32'h100, 1, 32'h200));
    vecs.push_back(mk("nt_ctr2",      0,0,1,0, 32'h100,32'hDEAD0, 32'h100, 1, 32'h200));
    vecs.push_back(mk("nt_ctr1",      0,0,1,0, 32'h100,32'hDEAD0, 32'h100, 0, 32'h104));
    vecs.push_back(mk("nt_ctr0",      0,0,1,0, 32'h100,32'hDEAD0, 32'h100, 0, 32'h104));
    vecs.push_back(mk("ctr0_miss",    0,0,0,0, 0,0, 32'h100, 0, 32'h104));
    vecs.push_back(mk("t_from0",      0,0,1,1, 32'h100,32'h200, 32'h100, 0, 32'h104));
    vecs.push_back(mk("ctr1_again",   0,0,0,0, 0,0, 32'h100, 0, 32'h104));
    vecs.push_back(mk("t_to2",        0,0,1,1, 32'h100,32'h200, 32'h100, 0, 32'h104));
    vecs.push_back(mk("ctr2_hit",     0,0,0,0, 0,0, 32'h100, 1, 32'h200));
    vecs.push_back(mk("alias_alloc",  0,0,1,1, 32'h140,32'h300, 32'h140, 0, 32'h144));
    vecs.push_back(mk("alias_hit",    0,0,0,0, 0,0, 32'h140, 1, 32'h300));
    vecs.push_back(mk("alias_evict",  0,0,0,0, 0,0, 32'h100, 0, 32'h104));
    vecs.push_back(mk("nt_miss_180",  0,0,1,0, 32'h180,32'h900, 32'h140, 1, 32'h300));
    vecs.push_back(mk("nt_miss_hold", 0,0,0,0, 0,0, 32'h140, 1, 32'h300));
    vecs.push_back(mk("nt_miss_180b", 0,0,0,0, 0,0, 32'h180, 0, 32'h184));
    vecs.push_back(mk("pc_wrap",      0,0,0,0, 0,0, 32'hFFFFFFFC, 0, 32'h0));
    vecs.push_back(mk("idx1_alloc",   0,0,1,1, 32'h104,32'h400, 32'h104, 0, 32'h108));
    vecs.push_back(mk("idx1_hit",     0,0,0,0, 0,0, 32'h104, 1, 32'h400));
    vecs.push_back(mk("idx0_hold",    0,0,0,0, 0,0, 32'h140, 1, 32'h300));
    vecs.push_back(mk("byte_ofs",     0,0,0,0, 0,0, 32'h106, 1, 32'h400));
    vecs.push_back(mk("flush_upd",    0,1,1,1, 32'h108,32'h500, 32'h140, 1, 32'h300));
    vecs.push_back(mk("flush_idx0",   0,0,0,0, 0,0, 32'h140, 0, 32'h144));
    vecs.push_back(mk("flush_idx1",   0,0,0,0, 0,0, 32'h104, 0, 32'h108));
    vecs.push_back(mk("flush_drop",   0,0,0,0, 0,0, 32'h108, 0, 32'h10C));
    vecs.push_back(mk("realloc",      0,0,1,1, 32'h100,32'h200, 32'h100, 0, 32'h104));
    vecs.push_back(mk("realloc_hit",  0,0,0,0, 0,0, 32'h100, 1, 32'h200));
    vecs.push_back(mk("rst_upd",      1,0,1,1, 32'h104,32'h400, 32'h100, 1, 32'h200));
    vecs.push_back(mk("rst_clear",    0,0,0,0, 0,0, 32'h100, 0, 32'h104));
    vecs.push_back(mk("rst_drop",     0,0,0,0, 0,0, 32'h104, 0, 32'h108));

    foreach (vecs[i]) apply(vecs[i]);

    // fill every index, then confirm each holds its own target
    for (int i = 0; i < 16; i++) begin
      apply(mk("fill", 0,0,1,1, 32'h1000 + 32'(i*4), 32'h8000 + 32'(i*16),
               32'h2000, 0, 32'h2004));
    end
    for (int i = 0; i < 16; i++) begin
      apply(mk("fill_hit", 0,0,0,0, 0,0, 32'h1000 + 32'(i*4),
               1, 32'h8000 + 32'(i*16)));
    end
    apply(mk("fill_flush", 0,1,0,0, 0,0, 32'h1000, 1, 32'h8000));
    for (int i = 0; i < 16; i++) begin
      apply(mk("fill_gone", 0,0,0,0, 0,0, 32'h1000 + 32'(i*4),
               0, 32'h1004 + 32'(i*4)));
    end

    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL sb_drain: got %0d left, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
